// File: rtl/prod_bcd_converter.sv
// Sequential binary-to-BCD converter for the multiplier product.
// Detects a change on in_data, runs a one-bit-per-clock double-dabble, and publishes the result with a valid pulse.
module prod_bcd_converter #(
  parameter int IN_W   = 17,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       in_data,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  valid,
  output logic                  busy
);

  localparam int CNT_W = $clog2(IN_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [1:0]          state;
  logic [IN_W-1:0]     last_val;
  logic [IN_W-1:0]     bin_sr;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adjusted;
  logic [CNT_W-1:0]    cnt;

  // Per-digit add-3 correction; a digit >= 5 plus 3 never exceeds 12, so no carry leaves the nibble.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
      assign adjusted[4*gi +: 4] = (scratch[4*gi +: 4] >= 4'd5) ?
                                   (scratch[4*gi +: 4] + 4'd3) : scratch[4*gi +: 4];
    end
  endgenerate

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_val <= '0;
      bin_sr   <= '0;
      scratch  <= '0;
      cnt      <= '0;
      bcd_out  <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_data != last_val) begin
            bin_sr   <= in_data;
            last_val <= in_data;
            scratch  <= '0;
            cnt      <= CNT_W'(IN_W);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {adjusted[4*DIGITS-2:0], bin_sr[IN_W-1]};
          bin_sr  <= {bin_sr[IN_W-2:0], 1'b0};
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd_out <= scratch;
          valid   <= 1'b1;
          state   <= IDLE;
        end
        WAIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/prod_bcd_converter.md
# prod_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of `top_hex_multiplier` and consumes its 17-bit `out_data` product. It detects when the product value changes, converts it with a shift-and-add-3 (double-dabble) engine one bit per clock, and presents a stable 6-digit BCD result with a one-cycle valid pulse, ready for a display or reporting stage.

## Interface

- `IN_W`, default 17: binary input width; it matches the multiplier's `out_data` width.
- `DIGITS`, default 6: BCD digit count; the requirement 10^DIGITS > 2^IN_W − 1 must hold.

- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_data`  in  IN_W  binary product from the multiplier's `out_data`.
- `bcd_out`  out  4*DIGITS  registered BCD result; the least significant digit is in [3:0].
- `valid`  out  1  one-cycle pulse; `bcd_out` was updated on the same edge.
- `busy`  out  1  high whenever `state != IDLE`.

## Operation

- The FSM has four states: IDLE, SHIFT, DONE, and WAIT. WAIT is reserved and unused; if the FSM ever encodes it, the next state is IDLE.
- `last_val` (IN_W bits) holds the last value accepted for conversion.
- IDLE behaviour:
  - If `in_data != last_val`, the FSM does the following on that edge, then moves to SHIFT:
    - Latch `in_data` into `bin_sr` and into `last_val`.
    - Clear the BCD scratch register (`4*DIGITS` bits).
    - Load `cnt = IN_W`.
  - Otherwise the FSM stays in IDLE.
- SHIFT behaviour, once per cycle:
  - Each scratch digit ≥ 5 gets +3 added.
  - Then {scratch, `bin_sr`} shifts left 1.
  - `cnt` decrements by 1.
  - When `cnt` reaches 0 after the shift (the IN_W-th shift), the next state is DONE.
- DONE behaviour: `bcd_out <= scratch`, `valid <= 1`, next state IDLE.
- `in_data` is sampled only in IDLE. Changes during SHIFT or DONE are ignored until the return to IDLE. At that point the level compare against `last_val` picks up the newest value, so the output always converges to the final stable product.
- Intermediate multiplier values (during its COMPUTE states) may trigger conversions. This is allowed; only the last one matters.
- Arithmetic: the digit adjust is 4-bit with no carry out of a digit (a digit ≥ 5 plus 3 stays ≤ 12 before the shift). No overflow is possible for IN_W=17, DIGITS=6.

## Timing

- Reset values (asynchronous, immediate on `rst_n` low):
  - `bcd_out = 0`, `valid = 0`, `busy = 0`
  - `last_val = 0`, `bin_sr = 0`, scratch `= 0`, `cnt = 0`
  - state = IDLE
- Reset mid-conversion aborts immediately. The partial result is discarded and `bcd_out` returns to 0.
- Edge numbering for a conversion:
  - E0: capture edge, IDLE→SHIFT; `busy` goes high after E0.
  - E1..E17: the 17 shift edges; E17 transitions to DONE.
  - E18: `bcd_out` updates and `valid` rises; state→IDLE; `busy` low after E18.
  - E19: `valid` falls. A new capture can occur at E19 at the earliest.
- Latency: IN_W+1 = 18 cycles from the capture edge to `bcd_out`/`valid`. Minimum spacing between conversions is 19 cycles.
- After reset release with `in_data == 0`: no conversion, `valid` stays 0.
- After reset release with `in_data != 0`: capture happens at the first rising edge.
- `valid` never stays high for 2 consecutive cycles. `bcd_out` is constant except at DONE edges.
- Stable `in_data` equal to `last_val`: FSM stays in IDLE and no `valid` pulse occurs.

## Test plan

- Reset, then `in_data = 17'd110` (0x0A×0x0B) held → exactly one `valid` pulse 18 cycles after capture, with `bcd_out = 24'h000110`.
- `in_data = 37740` (0xFF×0x94) → `bcd_out = 24'h037740`. Next, `in_data = 35055` (0xAB×0xCD) → `bcd_out = 24'h035055`. Each value produces exactly one `valid` pulse.
- `in_data = 17'h1FFFF` → `bcd_out = 24'h131071`. Then `in_data = 0` → `bcd_out = 24'h000000` with one `valid` pulse.
- `in_data = 12345`, then changed to 54321 at shift edge E5:
  - The first result `24'h012345` completes with `valid`.
  - The second conversion captures at E19 and yields `24'h054321` at E37.
  - Exactly two `valid` pulses occur.
- Assert `rst_n = 0` at shift edge E8 of a conversion:
  - `bcd_out`, `valid`, and `busy` go to 0 immediately.
  - On release with `in_data = 999`, capture occurs at the first edge and `bcd_out = 24'h000999` 18 cycles later.
- Run the full multiplier bench product sequence through `top_hex_multiplier` into this block. After each product settles, `bcd_out` must equal the decimal value of `in_1*in_2`, and `busy` is low before each new operand pair.
